// File: rtl/imm_decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode_stage_if                                                  |
// | Upstream/downstream valid-ready bundle for the immediate decoder.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface imm_decode_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_i;
    logic                  ready_o;
    logic [31:0]           instr_i;
    logic [DATA_WIDTH-1:0] pc_i;
    logic                  flush_i;
    logic                  valid_o;
    logic                  ready_i;
    logic [31:0]           instr_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic [DATA_WIDTH-1:0] immop_o;
    logic [2:0]            immsrc_o;
    logic                  illegal_o;

    modport slave (
        input  valid_i, instr_i, pc_i, flush_i, ready_i,
        output ready_o, valid_o, instr_o, pc_o, immop_o, immsrc_o, illegal_o
    );

    modport master (
        output valid_i, instr_i, pc_i, flush_i, ready_i,
        input  ready_o, valid_o, instr_o, pc_o, immop_o, immsrc_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode_stage                                                     |
// | Opcode-driven RISC-V immediate decode behind a 2-entry skid buffer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module imm_decode_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  wire                  clk,
    input  wire                  rst,
    imm_decode_stage_if.slave    bus
);
    localparam logic [2:0] c_SRC_I    = 3'b000;
    localparam logic [2:0] c_SRC_S    = 3'b001;
    localparam logic [2:0] c_SRC_B    = 3'b010;
    localparam logic [2:0] c_SRC_J    = 3'b011;
    localparam logic [2:0] c_SRC_U    = 3'b100;
    localparam logic [2:0] c_SRC_Z    = 3'b101;
    localparam logic [2:0] c_SRC_SH   = 3'b110;
    localparam logic [2:0] c_SRC_NONE = 3'b111;

    typedef struct packed {
        logic [31:0]           instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [2:0]            src;
        logic                  illegal;
    } payload_t;

    localparam payload_t c_PAY_RST = '{instr: '0, pc: '0, imm: '0,
                                       src: c_SRC_NONE, illegal: 1'b0};

    logic [31:0]           w_instr;
    logic [6:0]            w_opcode;
    logic [2:0]            w_funct3;
    logic [31:0]           w_shamt;
    logic [31:0]           w_imm32;
    logic [DATA_WIDTH-1:0] w_imm_ext;
    logic [2:0]            w_src;
    logic                  w_illegal;
    logic                  w_accept;
    payload_t              w_in_pay;

    logic     out_valid_q,  out_valid_d;
    logic     skid_valid_q, skid_valid_d;
    payload_t out_pay_q,    out_pay_d;
    payload_t skid_pay_q,   skid_pay_d;

    assign w_instr  = bus.instr_i;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];

    // Every immediate is formed in 32 bits; the zero-extended forms have
    // bit 31 clear, so a single sign extension covers all of them on RV64.
    generate
        if (DATA_WIDTH == 64) begin : g_rv64
            assign w_shamt   = {26'b0, w_instr[25:20]};
            assign w_imm_ext = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_rv32
            assign w_shamt   = {27'b0, w_instr[24:20]};
            assign w_imm_ext = w_imm32;
        end
    endgenerate

    always_comb begin
        w_src     = c_SRC_NONE;
        w_imm32   = '0;
        w_illegal = 1'b0;
        case (w_opcode)
            7'b0000011, 7'b1100111: begin
                w_src   = c_SRC_I;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
            end
            7'b0010011: begin
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_src   = c_SRC_SH;
                    w_imm32 = w_shamt;
                end else begin
                    w_src   = c_SRC_I;
                    w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                end
            end
            7'b0100011: begin
                w_src   = c_SRC_S;
                w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            end
            7'b1100011: begin
                w_src   = c_SRC_B;
                w_imm32 = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                           w_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                w_src   = c_SRC_J;
                w_imm32 = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                           w_instr[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                w_src   = c_SRC_U;
                w_imm32 = {w_instr[31:12], 12'b0};
            end
            7'b1110011: begin
                if (w_funct3[2]) begin
                    w_src   = c_SRC_Z;
                    w_imm32 = {27'b0, w_instr[19:15]};
                end else begin
                    w_src   = c_SRC_I;
                    w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
                end
            end
            7'b0110011, 7'b0001111: begin
                w_src = c_SRC_NONE;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_in_pay = '{instr: w_instr, pc: bus.pc_i, imm: w_imm_ext,
                        src: w_src, illegal: w_illegal};
    assign w_accept = bus.valid_i & ~skid_valid_q & ~bus.flush_i;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_pay_d    = out_pay_q;
        skid_pay_d   = skid_pay_q;
        if (bus.flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || bus.ready_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_pay_d    = skid_pay_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = w_accept;
                if (w_accept) begin
                    out_pay_d = w_in_pay;
                end
            end
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = w_in_pay;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_pay_q    <= c_PAY_RST;
            skid_pay_q   <= c_PAY_RST;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_pay_q    <= out_pay_d;
            skid_pay_q   <= skid_pay_d;
        end
    end

    // ready_o depends only on held state, never on ready_i.
    assign bus.ready_o   = ~skid_valid_q;
    assign bus.valid_o   = out_valid_q;
    assign bus.instr_o   = out_pay_q.instr;
    assign bus.pc_o      = out_pay_q.pc;
    assign bus.immop_o   = out_pay_q.imm;
    assign bus.immsrc_o  = out_pay_q.src;
    assign bus.illegal_o = out_pay_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imm_decode_stage                                                  |
// | Directed vector table plus back-pressure, flush and reset sequences. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_imm_decode_stage;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    imm_decode_stage_if #(.DATA_WIDTH(32)) bus32 ();
    imm_decode_stage_if #(.DATA_WIDTH(64)) bus64 ();

    imm_decode_stage #(.DATA_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_decode_stage #(.DATA_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  src;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  src;
    } vec64_t;

    vec_t   vecs[17];
    vec64_t vecs64[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        bus32.valid_i = v;
        bus32.instr_i = ins;
        bus32.pc_i    = ins ^ 32'h5A5A_0000;
        bus32.ready_i = rdy;
        bus32.flush_i = fl;
    endtask

    task automatic check_out(input string name, input logic [31:0] ins);
        check({name, " valid"}, 64'(bus32.valid_o), 64'd1);
        check({name, " instr"}, 64'(bus32.instr_o), 64'(ins));
        check({name, " pc"}, 64'(bus32.pc_o), 64'(ins ^ 32'h5A5A_0000));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, c, d;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'b000, 1'b0};
        vecs[1]  = '{32'hFE20AE23, 32'hFFFFFFFC, 3'b001, 1'b0};
        vecs[2]  = '{32'h001000EF, 32'h00000800, 3'b011, 1'b0};
        vecs[3]  = '{32'h123452B7, 32'h12345000, 3'b100, 1'b0};
        vecs[4]  = '{32'h4030D093, 32'h00000003, 3'b110, 1'b0};
        vecs[5]  = '{32'h3002D073, 32'h00000005, 3'b101, 1'b0};
        vecs[6]  = '{32'h0000007F, 32'h00000000, 3'b111, 1'b1};
        vecs[7]  = '{32'h00A00513, 32'h0000000A, 3'b000, 1'b0};
        vecs[8]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'b010, 1'b0};
        vecs[9]  = '{32'h00000033, 32'h00000000, 3'b111, 1'b0};
        vecs[10] = '{32'h0000000F, 32'h00000000, 3'b111, 1'b0};
        vecs[11] = '{32'h80002083, 32'hFFFFF800, 3'b000, 1'b0};
        vecs[12] = '{32'h7FF08067, 32'h000007FF, 3'b000, 1'b0};
        vecs[13] = '{32'hFFFFF297, 32'hFFFFF000, 3'b100, 1'b0};
        vecs[14] = '{32'h30029073, 32'h00000300, 3'b000, 1'b0};
        vecs[15] = '{32'h03F09093, 32'h0000001F, 3'b110, 1'b0};
        vecs[16] = '{32'h00000073, 32'h00000000, 3'b000, 1'b0};

        vecs64[0] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'b100};
        vecs64[1] = '{32'h03F09093, 64'h000000000000003F, 3'b110};
        vecs64[2] = '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'b000};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        bus64.valid_i = 1'b0;
        bus64.instr_i = '0;
        bus64.pc_i    = '0;
        bus64.ready_i = 1'b1;
        bus64.flush_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst valid_o", 64'(bus32.valid_o), 64'd0);
        check("rst ready_o", 64'(bus32.ready_o), 64'd1);
        check("rst instr_o", 64'(bus32.instr_o), 64'd0);
        check("rst pc_o", 64'(bus32.pc_o), 64'd0);
        check("rst immop_o", 64'(bus32.immop_o), 64'd0);
        check("rst immsrc_o", 64'(bus32.immsrc_o), 64'd7);
        check("rst illegal_o", 64'(bus32.illegal_o), 64'd0);
        check("rst64 immsrc_o", 64'(bus64.immsrc_o), 64'd7);

        // Streamed decode sweep: each vector is checked one cycle after it is offered.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, vecs[i].instr, 1'b1, 1'b0);
            tick();
            check($sformatf("v%0d valid", i), 64'(bus32.valid_o), 64'd1);
            check($sformatf("v%0d instr", i), 64'(bus32.instr_o), 64'(vecs[i].instr));
            check($sformatf("v%0d pc", i), 64'(bus32.pc_o), 64'(vecs[i].instr ^ 32'h5A5A_0000));
            check($sformatf("v%0d imm", i), 64'(bus32.immop_o), 64'(vecs[i].imm));
            check($sformatf("v%0d src", i), 64'(bus32.immsrc_o), 64'(vecs[i].src));
            check($sformatf("v%0d ill", i), 64'(bus32.illegal_o), 64'(vecs[i].ill));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check("sweep drain valid", 64'(bus32.valid_o), 64'd0);

        for (int i = 0; i < 3; i++) begin
            bus64.valid_i = 1'b1;
            bus64.instr_i = vecs64[i].instr;
            bus64.pc_i    = 64'h8000_0000_0000_0000 + 64'(i);
            tick();
            check($sformatf("w%0d valid", i), 64'(bus64.valid_o), 64'd1);
            check($sformatf("w%0d pc", i), bus64.pc_o, 64'h8000_0000_0000_0000 + 64'(i));
            check($sformatf("w%0d imm", i), bus64.immop_o, vecs64[i].imm);
            check($sformatf("w%0d src", i), 64'(bus64.immsrc_o), 64'(vecs64[i].src));
        end
        bus64.valid_i = 1'b0;
        tick();

        // Back-pressure: A, B, C, D with ready_i low on cycles 2-4.
        a = 32'hFFF00093; b = 32'h123452B7; c = 32'h00A00513; d = 32'hFE20AE23;
        drive(1'b1, a, 1'b1, 1'b0); tick();
        check_out("bp1 A", a);
        check("bp1 ready_o", 64'(bus32.ready_o), 64'd1);
        drive(1'b1, b, 1'b0, 1'b0); tick();
        check_out("bp2 A", a);
        check("bp2 ready_o", 64'(bus32.ready_o), 64'd0);
        drive(1'b1, c, 1'b0, 1'b0); tick();
        check_out("bp3 A", a);
        check("bp3 imm", 64'(bus32.immop_o), 64'hFFFFFFFF);
        check("bp3 ready_o", 64'(bus32.ready_o), 64'd0);
        drive(1'b1, c, 1'b0, 1'b0); tick();
        check_out("bp4 A", a);
        drive(1'b1, c, 1'b1, 1'b0); tick();
        check_out("bp5 B", b);
        check("bp5 imm", 64'(bus32.immop_o), 64'h12345000);
        check("bp5 ready_o", 64'(bus32.ready_o), 64'd1);
        drive(1'b1, c, 1'b1, 1'b0); tick();
        check_out("bp6 C", c);
        drive(1'b1, d, 1'b1, 1'b0); tick();
        check_out("bp7 D", d);
        check("bp7 imm", 64'(bus32.immop_o), 64'hFFFFFFFC);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("bp8 valid", 64'(bus32.valid_o), 64'd0);

        // Flush with output and skid both full and a new instruction offered.
        drive(1'b1, a, 1'b1, 1'b0); tick();
        drive(1'b1, b, 1'b0, 1'b0); tick();
        check("fl pre ready_o", 64'(bus32.ready_o), 64'd0);
        drive(1'b1, c, 1'b0, 1'b1); tick();
        check("fl valid", 64'(bus32.valid_o), 64'd0);
        check("fl ready_o", 64'(bus32.ready_o), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("fl post valid", 64'(bus32.valid_o), 64'd0);

        // Flush beats an accept that ready_o would otherwise allow.
        drive(1'b1, a, 1'b1, 1'b0); tick();
        drive(1'b1, d, 1'b1, 1'b1); tick();
        check("fl2 valid", 64'(bus32.valid_o), 64'd0);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("fl2 post valid", 64'(bus32.valid_o), 64'd0);

        // Asynchronous reset between edges while two entries are held.
        drive(1'b1, a, 1'b1, 1'b0); tick();
        drive(1'b1, b, 1'b0, 1'b0); tick();
        check("ar pre ready_o", 64'(bus32.ready_o), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("ar valid_o", 64'(bus32.valid_o), 64'd0);
        check("ar ready_o", 64'(bus32.ready_o), 64'd1);
        check("ar instr_o", 64'(bus32.instr_o), 64'd0);
        check("ar immsrc_o", 64'(bus32.immsrc_o), 64'd7);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1 rst = 1'b0;
        tick();
        check("ar idle valid", 64'(bus32.valid_o), 64'd0);
        drive(1'b1, d, 1'b1, 1'b0); tick();
        check_out("ar resume D", d);
        check("ar resume imm", 64'(bus32.immop_o), 64'hFFFFFFFC);
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        check("ar end valid", 64'(bus32.valid_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
